// File: rtl/q_window_counter_pkg.sv
// Shared types and defaults for the Q-transition window counter.
package q_window_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      HOLD  = 2'b10
   } state_t;

   localparam int CNT_W_DEF = 8;
   localparam int WIN_W_DEF = 8;
endpackage

// File: rtl/q_window_counter_if.sv
// Control/result bundle between a window-counter client (master) and the counter (slave).
interface q_window_counter_if
   import q_window_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
);
   logic             Start;
   logic [WIN_W-1:0] Win_len;
   logic             Ready;
   logic [CNT_W-1:0] Count;
   logic             Ovf;
   logic             Valid;
   logic             Busy;

   modport master (output Start, Win_len, Ready, input Count, Ovf, Valid, Busy);
   modport slave  (input Start, Win_len, Ready, output Count, Ovf, Valid, Busy);
endinterface

// File: rtl/q_window_counter_edge_detect.sv
// Edge detector on Q_in against its previous-cycle sample.
// Q_BOTH_EDGES_EN: count any transition instead of rising edges only.
module q_edge_detect (
   input  logic Clk,
   input  logic Rst,
   input  logic Q_in,
   output logic q_event
);
   logic q_prev_q, q_prev_d;

   always_comb q_prev_d = Q_in;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) q_prev_q <= 1'b0;
      else     q_prev_q <= q_prev_d;
   end

`ifdef Q_BOTH_EDGES_EN
   assign q_event = Q_in ^ q_prev_q;
`else
   assign q_event = Q_in & ~q_prev_q;
`endif
endmodule

// File: rtl/q_window_counter.sv
// Counts Q_in events over a Win_len-cycle window and holds the result for a valid/ready reader.
// Q_BOTH_EDGES_EN selects any-transition counting in the edge detector.
module q_window_counter
   import q_window_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                Q_in,
   q_window_counter_if.slave   bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             q_event;

   q_edge_detect u_edge (
      .Clk     (Clk),
      .Rst     (Rst),
      .Q_in    (Q_in),
      .q_event (q_event)
   );

   always_comb begin
      state_d   = state_q;
      win_cnt_d = win_cnt_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               win_cnt_d = bus.Win_len;
               count_d   = '0;
               ovf_d     = 1'b0;
               state_d   = (bus.Win_len == '0) ? HOLD : COUNT;
            end
         end
         COUNT: begin
            if (q_event) begin
               if (count_q == CNT_MAX) ovf_d   = 1'b1;
               else                    count_d = count_q + CNT_W'(1);
            end
            win_cnt_d = win_cnt_q - WIN_W'(1);
            if (win_cnt_q == WIN_W'(1)) state_d = HOLD;
         end
         HOLD: begin
            if (bus.Ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= IDLE;
         win_cnt_q <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_cnt_q <= win_cnt_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.Count = count_q;
   assign bus.Ovf   = ovf_q;
   assign bus.Valid = (state_q == HOLD);
   assign bus.Busy  = (state_q != IDLE);
endmodule

// File: tb/tb_q_window_counter.sv
// Bench for q_window_counter: an 8-bit and a 2-bit counter share one stimulus stream.
module tb_q_window_counter;
   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       q_in = 1'b0;
   logic       start = 1'b0;
   logic [7:0] win_len = '0;
   logic       ready = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 Clk = ~Clk;

   q_window_counter_if #(.CNT_W(8), .WIN_W(8)) if8 ();
   q_window_counter_if #(.CNT_W(2), .WIN_W(8)) if2 ();

   assign if8.Start = start;  assign if8.Win_len = win_len;  assign if8.Ready = ready;
   assign if2.Start = start;  assign if2.Win_len = win_len;  assign if2.Ready = ready;

   q_window_counter #(.CNT_W(8), .WIN_W(8)) dut8 (.Clk(Clk), .Rst(Rst), .Q_in(q_in), .bus(if8));
   q_window_counter #(.CNT_W(2), .WIN_W(8)) dut2 (.Clk(Clk), .Rst(Rst), .Q_in(q_in), .bus(if2));

   // seq bit 0 = Q_in in the Start cycle, bits 1..N = COUNT cycles, bit N+1 = first HOLD cycle
   typedef struct {
      logic [7:0]  n;
      logic [31:0] seq;
      int          exp_r;
      int          exp_b;
   } vec_t;

   typedef struct {
      int cnt8;
      int ovf8;
      int cnt2;
      int ovf2;
      int lat;
   } exp_t;

   vec_t tbl[6];
   exp_t sb[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      exp_t e, got_e;
      int   cnt;
      bit   got;
      v = tbl[idx];
`ifdef Q_BOTH_EDGES_EN
      cnt = v.exp_b;
`else
      cnt = v.exp_r;
`endif
      tick(); start = 1'b0; q_in = 1'b0; ready = 1'b1; win_len = v.n;
      tick(); start = 1'b1; q_in = v.seq[0];
      e.cnt8 = cnt;  e.ovf8 = 0;
      e.cnt2 = (cnt > 3) ? 3 : cnt;  e.ovf2 = (cnt > 3) ? 1 : 0;
      e.lat = int'(v.n) + 1;
      sb.push_back(e);
      @(negedge Clk);
      chk($sformatf("v%0d busy_at_start", idx), int'(if8.Busy), 0);
      got = 1'b0;
      for (int k = 1; k < 40 && !got; k++) begin
         tick(); start = 1'b0; q_in = (k < 32) ? v.seq[k] : 1'b0;
         @(negedge Clk);
         if (if8.Valid) begin
            got = 1'b1;
            got_e = sb.pop_front();
            chk($sformatf("v%0d latency", idx), k, got_e.lat);
            chk($sformatf("v%0d valid2", idx), int'(if2.Valid), 1);
            chk($sformatf("v%0d count8", idx), int'(if8.Count), got_e.cnt8);
            chk($sformatf("v%0d ovf8", idx), int'(if8.Ovf), got_e.ovf8);
            chk($sformatf("v%0d count2", idx), int'(if2.Count), got_e.cnt2);
            chk($sformatf("v%0d ovf2", idx), int'(if2.Ovf), got_e.ovf2);
         end
      end
      if (!got) begin
         chk($sformatf("v%0d valid_timeout", idx), 0, 1);
         void'(sb.pop_front());
      end
      tick(); q_in = 1'b0;
      @(negedge Clk);
      chk($sformatf("v%0d valid_drop", idx), int'(if8.Valid), 0);
      chk($sformatf("v%0d busy_drop", idx), int'(if8.Busy), 0);
   endtask

   initial begin
      int hold_cnt;
      tbl[0] = '{n: 8'd8,  seq: 32'h0000_0155, exp_r: 4, exp_b: 8};   // basic toggle
      tbl[1] = '{n: 8'd0,  seq: 32'h0000_0005, exp_r: 0, exp_b: 0};   // zero window
      tbl[2] = '{n: 8'd20, seq: 32'h0000_1554, exp_r: 6, exp_b: 12};  // saturates 2-bit
      tbl[3] = '{n: 8'd4,  seq: 32'h0000_002F, exp_r: 0, exp_b: 1};   // edges at Start/HOLD only
      tbl[4] = '{n: 8'd1,  seq: 32'h0000_0002, exp_r: 1, exp_b: 1};
      tbl[5] = '{n: 8'd3,  seq: 32'h0000_001E, exp_r: 1, exp_b: 1};

      // reset state
      #12;
      chk("rst count8", int'(if8.Count), 0);
      chk("rst ovf8",   int'(if8.Ovf), 0);
      chk("rst valid8", int'(if8.Valid), 0);
      chk("rst busy8",  int'(if8.Busy), 0);
      chk("rst busy2",  int'(if2.Busy), 0);
      @(negedge Clk); Rst = 1'b0;

      // asynchronous reset mid-window with Count=3
      tick(); win_len = 8'd10; start = 1'b1; q_in = 1'b0; ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick(); start = 1'b0; q_in = k[0];
      end
      tick(); q_in = 1'b0;
`ifdef Q_BOTH_EDGES_EN
      chk("mid count8", int'(if8.Count), 6);
`else
      chk("mid count8", int'(if8.Count), 3);
`endif
      chk("mid busy8", int'(if8.Busy), 1);
      #2 Rst = 1'b1;
      #1;
      chk("arst count8", int'(if8.Count), 0);
      chk("arst ovf2",   int'(if2.Ovf), 0);
      chk("arst valid8", int'(if8.Valid), 0);
      chk("arst busy8",  int'(if8.Busy), 0);
      @(negedge Clk); Rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(i);

      // back-pressure: Ready low in HOLD while Start pulses and Q_in toggles
`ifdef Q_BOTH_EDGES_EN
      hold_cnt = 2;
`else
      hold_cnt = 1;
`endif
      tick(); win_len = 8'd2; start = 1'b1; q_in = 1'b0; ready = 1'b0;
      tick(); start = 1'b1; q_in = 1'b1;
      tick(); start = 1'b0; q_in = 1'b0;
      tick(); start = 1'b1; q_in = 1'b1;
      @(negedge Clk);
      chk("bp valid_enter", int'(if8.Valid), 1);
      for (int k = 0; k < 5; k++) begin
         tick(); start = ~start; q_in = ~q_in;
         @(negedge Clk);
         chk($sformatf("bp valid_hold%0d", k), int'(if8.Valid), 1);
         chk($sformatf("bp count_hold%0d", k), int'(if8.Count), hold_cnt);
      end
      tick(); start = 1'b0; ready = 1'b1;
      @(negedge Clk);
      chk("bp valid_accept", int'(if8.Valid), 1);
      tick();
      @(negedge Clk);
      chk("bp valid_drop", int'(if8.Valid), 0);
      chk("bp busy_drop",  int'(if8.Busy), 0);
      tick();
      @(negedge Clk);
      chk("bp start_ignored", int'(if8.Busy), 0);
      chk("bp count_kept", int'(if8.Count), hold_cnt);
      chk("sb empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end
endmodule

// File: doc/q_window_counter.md
# q_window_counter

Downstream consumer of the registered combinational-detect output `Q` from the `System` stage. Counts transitions on `Q_in` over a programmable window of clock cycles. Holds the result until a downstream reader accepts it through a valid/ready handshake. Gives the team an event-rate measurement of the detect condition without software polling.

## Interface
- `CNT_W`, default 8: width of the event count.
- `WIN_W`, default 8: width of the window-length input and of the internal window counter.

- `Clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `Rst`: input, 1 bit. Reset, asynchronous and active-high.
- `Q_in`: input, 1 bit. Detect output from the upstream flop, same clock domain.
- `Start`: input, 1 bit. Begins a measurement window; sampled only in IDLE.
- `Win_len`: input, `WIN_W` bits. Window length N in cycles; latched when `Start` is accepted.
- `Ready`: input, 1 bit. Downstream accepts the result.
- `Count`: output, `CNT_W` bits. Number of events counted in the window.
- `Ovf`: output, 1 bit. Set when the count saturated during the window.
- `Valid`: output, 1 bit. `Count` and `Ovf` hold a completed result.
- `Busy`: output, 1 bit. High in COUNT and HOLD.

## Operation
- `q_prev` register samples `Q_in` every cycle, in every state.
- An event is a rising edge: `Q_in`=1 and `q_prev`=0.
- FSM states: IDLE, COUNT, HOLD.
- **IDLE**
  - `Start`=1 latches `Win_len` into `win_cnt` and clears `Count` and `Ovf`.
  - Next state is COUNT, or HOLD when `Win_len`=0.
- **COUNT**
  - Each cycle: if an event is seen, `Count` increments; `win_cnt` decrements.
  - The cycle in which `win_cnt`=1 is the last counted cycle. Next state is HOLD.
- **HOLD**
  - `Valid`=1; `Count` and `Ovf` stay stable.
  - `Valid` && `Ready` returns the FSM to IDLE on the next edge.
- Saturation: at `Count` = 2^`CNT_W`−1, further events leave `Count` unchanged and set `Ovf`=1. `Ovf` stays sticky until the next accepted `Start`.
- `Start` in COUNT or HOLD is ignored. No queuing.
- `Ready` outside HOLD is ignored.
- An event is counted only in COUNT cycles. An edge in the `Start` cycle or in the first HOLD cycle is not counted.

## Timing
- Reset values: `Count`=0, `Ovf`=0, `Valid`=0, `Busy`=0; state IDLE; `q_prev`=0; `win_cnt`=0.
- Reset asserted mid-window or mid-HOLD aborts immediately and asynchronously to the reset values; the result is discarded.
- Sequence, with `Start` accepted at edge t:
  - COUNT occupies cycles t+1 … t+N.
  - `Valid` rises after edge t+N+1.
  - Latency from `Start` to `Valid` is N+1 cycles.
- `Win_len`=0: `Valid` rises after edge t+1 with `Count`=0.
- Handshake: `Valid` falls on the edge following `Valid` && `Ready`. A new `Start` is accepted one cycle later, at the earliest.
- Events are counted combinationally from `Q_in` against `q_prev`, with no extra pipeline delay.
- `Q_in` is assumed glitch-free at the rising edge, because the upstream flop changes on the falling edge.

## Configuration
- Macro `Q_BOTH_EDGES_EN`.
- Defined: an event is any transition (`Q_in` != `q_prev`), so rising and falling edges are both counted.
- Undefined: rising edges only, as described above.
- Saturation, `Ovf` and handshake behaviour are identical in both builds.

## Structure
- Package `q_window_pkg`:
  - state typedef: IDLE=2'b00, COUNT=2'b01, HOLD=2'b10;
  - default constants `CNT_W_DEF`=8 and `WIN_W_DEF`=8.
- Sub-module `q_edge_detect`:
  - contains `q_prev` and produces a one-bit `event` output;
  - honours `Q_BOTH_EDGES_EN`.
- FSM, window counter and saturating count stay in the top module.

## Test plan
1. **Reset mid-window.** Assert `Rst` mid-window with `Count`=3 → all outputs 0 immediately, state IDLE; a new `Start` afterwards works.
2. **Basic count.** `Win_len`=8; `Q_in` toggles 0,1,0,1,… from cycle t+1; `Ready`=1.
   - Rising-edge build: `Count`=4, `Ovf`=0.
   - `Q_BOTH_EDGES_EN` build: `Count`=8.
   - `Valid` asserts at t+9 and drops at t+10.
3. **Zero window.** `Win_len`=0 with `Q_in` toggling → `Valid` at t+1, `Count`=0.
4. **Saturation.** `CNT_W`=2, `Win_len`=20, 6 rising edges → `Count`=3, `Ovf`=1. The next `Start` clears `Ovf`.
5. **Back-pressure.** Hold `Ready`=0 for 5 cycles in HOLD and pulse `Start` and toggle `Q_in` throughout → `Count` is stable, `Start` is ignored, `Valid` stays high until `Ready`=1.
6. **Boundary edges.** Rising edge exactly at the `Start` cycle and at the first HOLD cycle, `Win_len`=4, no other edges → `Count`=0.
